aes128_encryptor_iter: RTL and testbench

- Iterative AES-128 encryptor (FIPS-197): one 128-bit plaintext block in, one ciphertext block out.
- Executes one full round per clock; round keys are expanded on the fly.
- Transmit-side counterpart of the team's decryptor: its output must decrypt back to the input under the same key.
- Sits between the host-facing block register and the link or storage path.

---
 rtl/aes128_encryptor_iter_if.sv | 23 ++
 rtl/aes128_encryptor_iter.sv | 223 ++++++++++++++++++++++
 tb/tb_aes128_encryptor_iter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes128_encryptor_iter_if.sv
// Block interface for the iterative AES-128 encryptor.
//   master: drives start/plaintext/key, observes ciphertext/busy/done (host side)
//   slave : the encryptor itself
interface aes128_encryptor_iter_if;
  localparam int unsigned BLK_W = 128;

  logic             start;
  logic [BLK_W-1:0] plaintext;
  logic [BLK_W-1:0] key;
  logic [BLK_W-1:0] ciphertext;
  logic             busy;
  logic             done;

  modport master (
    output start, plaintext, key,
    input  ciphertext, busy, done
  );

  modport slave (
    input  start, plaintext, key,
    output ciphertext, busy, done
  );
endinterface

// File: rtl/aes128_encryptor_iter.sv
// Iterative AES-128 encryptor: one full cipher round per clock, round keys
// expanded on the fly alongside the state.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset, clears all state
//   bus  - slave modport: start/plaintext/key in, ciphertext/busy/done out
//          (byte 0 of every block = bits [127:120])
module aes128_encryptor_iter #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  aes128_encryptor_iter_if.slave  bus
);

  localparam int unsigned BLK_W    = 128;
  localparam int unsigned RCNT_W   = 4;
  localparam logic [RCNT_W-1:0] LAST_RND = RCNT_W'(ROUNDS);

  // Only the AES-128 round count is implemented.
  if (ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_encryptor_iter: only ROUNDS=10 is supported");
  end

  // Standard AES S-box, entry x at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [RCNT_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Byte (row r, column c) sits at index r + 4c; row r rotates left by r columns.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c)   +: 8];
      a1 = s[8*(14-4*c)   +: 8];
      a2 = s[8*(13-4*c)   +: 8];
      a3 = s[8*(12-4*c)   +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One step of the AES-128 key schedule: previous round key -> next round key.
  function automatic logic [BLK_W-1:0] key_expand(input logic [BLK_W-1:0] k,
                                                  input logic [7:0]       rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e              state_q, state_nxt;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_nxt;
  logic [BLK_W-1:0]    st_q, st_nxt;
  logic [BLK_W-1:0]    rk_q, rk_nxt;
  logic [BLK_W-1:0]    ct_q, ct_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;

  logic [BLK_W-1:0]    rk_round;
  logic [BLK_W-1:0]    sr_out;
  logic [BLK_W-1:0]    mc_out;
  logic [BLK_W-1:0]    rnd_out;

  // Single-cycle round datapath; MixColumns skipped on the final round.
  always_comb begin
    rk_round = key_expand(rk_q, rcon(rcnt_q));
    sr_out   = shift_rows(sub_bytes(st_q));
    mc_out   = mix_columns(sr_out);
    rnd_out  = ((rcnt_q == LAST_RND) ? sr_out : mc_out) ^ rk_round;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    rcnt_nxt  = rcnt_q;
    st_nxt    = st_q;
    rk_nxt    = rk_q;
    ct_nxt    = ct_q;
    busy_nxt  = busy_q;
    done_nxt  = done_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_nxt    = bus.plaintext ^ bus.key;
          rk_nxt    = bus.key;
          rcnt_nxt  = RCNT_W'(1);
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (rcnt_q == '0 || rcnt_q > LAST_RND) begin
          // Out-of-range counter behaves as idle.
          rcnt_nxt  = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          st_nxt   = rnd_out;
          rk_nxt   = rk_round;
          rcnt_nxt = rcnt_q + RCNT_W'(1);
          if (rcnt_q == LAST_RND) begin
            ct_nxt    = rnd_out;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            rcnt_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        rcnt_nxt  = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rcnt_q  <= rcnt_nxt;
      st_q    <= st_nxt;
      rk_q    <= rk_nxt;
      ct_q    <= ct_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.ciphertext = ct_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes128_encryptor_iter.sv
// Directed bench for aes128_encryptor_iter using FIPS-197 vectors.
module tb_aes128_encryptor_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L_KEY  = 128'h6772696666696e746772696666696e74;
  localparam logic [127:0] L_PT   = 128'h636f6d7061726368636f6d7061726368;
  localparam logic [127:0] L_CT   = 128'h27a15792bba1cb6cba23475fdaa1cb1a;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  aes128_encryptor_iter_if bus ();

  aes128_encryptor_iter #(.ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single start pulse, exact 10-edge latency, previous result held meanwhile.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input logic [127:0] prev);
    bus.plaintext = pt;
    bus.key       = k;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " busy@accept"}, 128'(bus.busy), 128'(1));
    check({tag, " done@accept"}, 128'(bus.done), 128'(0));
    for (int i = 1; i <= 9; i++) begin
      tick();
      check({tag, " busy"}, 128'(bus.busy), 128'(1));
      check({tag, " done"}, 128'(bus.done), 128'(0));
      check({tag, " ct held"}, bus.ciphertext, prev);
    end
    tick();
    check({tag, " done@10"}, 128'(bus.done), 128'(1));
    check({tag, " busy@10"}, 128'(bus.busy), 128'(0));
    check({tag, " ct"}, bus.ciphertext, exp);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;

    // Reset held 3 cycles, then idle 20 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset outputs", {bus.ciphertext[125:0], bus.busy, bus.done}, 128'(0));
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle ct", bus.ciphertext, 128'(0));
      check("idle busy/done", 128'({bus.busy, bus.done}), 128'(0));
    end

    // FIPS-197 C.1.
    run_block("c1", C1_PT, C1_KEY, C1_CT, 128'(0));

    // App. B with all-ones inputs and a start pulse while busy.
    bus.plaintext = B_PT;
    bus.key       = B_KEY;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.plaintext = '1;
    bus.key       = '1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("appb busy mid", 128'(bus.busy), 128'(1));
    for (int i = 0; i < 7; i++) tick();
    check("appb done", 128'(bus.done), 128'(1));
    check("appb ct", bus.ciphertext, B_CT);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("appb no rerun busy", 128'(bus.busy), 128'(0));
      check("appb done level", 128'(bus.done), 128'(1));
      check("appb ct stable", bus.ciphertext, B_CT);
    end

    // Loopback vector.
    run_block("loop", L_PT, L_KEY, L_CT, B_CT);

    // start held high: one result every 11 cycles.
    bus.plaintext = C1_PT;
    bus.key       = C1_KEY;
    bus.start     = 1'b1;
    tick();
    for (int k = 1; k <= 43; k++) begin
      tick();
      check("b2b done", 128'(bus.done), 128'((k % 11) == 10));
      check("b2b busy", 128'(bus.busy), 128'((k % 11) != 10));
      if (k == 5) check("b2b ct held", bus.ciphertext, L_CT);
      if ((k % 11) == 10) check("b2b ct", bus.ciphertext, C1_CT);
    end
    bus.start = 1'b0;

    // Async reset during round 5, then a fresh run.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre-reset busy", 128'(bus.busy), 128'(1));
    rst = 1'b0;
    #1;
    check("async rst ct", bus.ciphertext, 128'(0));
    check("async rst busy", 128'(bus.busy), 128'(0));
    check("async rst done", 128'(bus.done), 128'(0));
    tick();
    tick();
    check("rst hold", {bus.ciphertext[125:0], bus.busy, bus.done}, 128'(0));
    rst = 1'b1;
    tick();
    check("post rst idle", 128'({bus.busy, bus.done}), 128'(0));
    run_block("c1 after rst", C1_PT, C1_KEY, C1_CT, 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
